// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner + 2-entry fetch queue feeding decode; HLT self-stop under FETCH_HALT_DETECT_EN.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] im_addr,
  output logic        im_rd_en,
  input  logic [15:0] im_instr,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [15:0] dec_instr,
  output logic [15:0] dec_pc,
  output logic [15:0] dec_pc_inc,
  output logic        halted
);
  logic [15:0] fetch_pc;
  logic [15:0] q_instr [2];
  logic [15:0] q_pc [2];
  logic [1:0]  count;
  logic [1:0]  tail;
  logic        deq;
  assign dec_valid  = count != 2'd0;
  assign dec_instr  = q_instr[0];
  assign dec_pc     = q_pc[0];
  assign dec_pc_inc = q_pc[0] + 16'd1;
  assign deq        = dec_valid & dec_ready;
  assign im_addr    = fetch_pc;
  assign im_rd_en   = ~rst & ~redirect & ~halted & ((count < 2'(QDEPTH)) | deq);
  assign tail       = count - {1'b0, deq};
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      count    <= 2'd0;
    end else begin
      count <= count + {1'b0, im_rd_en} - {1'b0, deq};
      if (deq && count[1]) begin
        q_instr[0] <= q_instr[1];
        q_pc[0]    <= q_pc[1];
      end
      if (im_rd_en) begin
        fetch_pc         <= fetch_pc + 16'd1;
        q_instr[tail[0]] <= im_instr;
        q_pc[tail[0]]    <= fetch_pc;
      end
    end
  end
`ifdef FETCH_HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst || redirect) halted <= 1'b0;
    else if (im_rd_en && im_instr[15:12] == 4'hF) halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the instruction memory (IM). Owns the program counter, drives the IM address/read-enable, captures the returned 16-bit instruction word into a 2-entry fetch queue, and presents instructions with their PCs to decode through a valid/ready handshake. Branch/jump redirects from execute flush the queue and restart fetch at the target.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset
- QDEPTH, 2, fetch queue entries (fixed at 2; other values unsupported)
- clk  in  1  system clock; IM latches on clk low, so IM data is stable at the next rising edge
- rst  in  1  synchronous, active-high reset
- im_addr  out  16  address to IM
- im_rd_en  out  1  IM read enable
- im_instr  in  16  instruction word from IM
- redirect  in  1  flush and restart fetch
- redirect_pc  in  16  target PC, sampled when redirect=1
- dec_ready  in  1  decode accepts head entry this cycle
- dec_valid  out  1  head entry valid
- dec_instr  out  16  head instruction
- dec_pc  out  16  PC of head instruction
- dec_pc_inc  out  16  dec_pc + 1
- halted  out  1  fetch stopped on HLT (see Configuration)

## Operation
- State: fetch_pc[15:0], queue of {instr, pc} x2 with count[1:0], halted.
- Issue: im_addr = fetch_pc; im_rd_en = ~rst & ~redirect & ~halted & (count<2 | deq), where deq = dec_valid & dec_ready.
- Capture: if im_rd_en at a rising edge, {im_instr, fetch_pc} is written to the queue tail and fetch_pc <= fetch_pc + 1 (16-bit wrap, FFFF -> 0000).
- Dequeue: deq pops the head; head-to-tail ordering preserved.
- Simultaneous enqueue+dequeue: count unchanged; allowed when full.
- Full (count=2) and no deq: im_rd_en=0, fetch_pc held.
- Empty: dec_valid=0; dec_instr/dec_pc hold last values (don't care).
- Redirect (highest priority): at the edge, queue cleared (count=0), fetch_pc <= redirect_pc, halted <= 0; no capture that cycle; any dec_ready that cycle is ignored for state (decode must treat its own handshake that cycle as squashed).
- Reset: fetch_pc=RESET_PC, count=0, halted=0; dec_valid=0, im_rd_en=0 while rst=1, halted=0.

## Timing
- Fetch latency: address issued in cycle N -> instruction at dec_* with dec_valid=1 in cycle N+1 (when queue was empty).
- Sustained throughput 1 instr/cycle with dec_ready held high.
- Redirect in cycle N -> target issued on im_addr in N+1 -> valid at decode in N+2.
- Deassert of rst at edge E -> first im_rd_en=1 in cycle after E with im_addr=RESET_PC.
- Reset asserted mid-stream overrides redirect and all queue activity at the same edge.
- All outputs registered except im_addr/im_rd_en (combinational from state + redirect/dec_ready) and dec_pc_inc (adder from head PC).

## Configuration
- FETCH_HALT_DETECT_EN defined: a captured word with im_instr[15:12]==4'hF sets halted at that edge; fetch stops (im_rd_en=0) after the HLT is enqueued; HLT still delivered to decode; cleared only by rst or redirect.
- Undefined: halted tied 0; fetch never self-stops.

## Test plan
- Reset, IM[0..3]=1000,2001,3002,4003, dec_ready=1 -> dec_instr 1000,2001,3002,4003 on consecutive cycles starting 1 cycle after rst drops, dec_pc 0..3.
- dec_ready=0 for 4 cycles after first valid -> queue holds 2 entries, im_rd_en=0 by cycle 3, no instruction lost or duplicated after dec_ready=1.
- Redirect to 16'h0040 while queue full -> next valid is IM[0x40] with dec_pc=0x0040 two cycles later; old entries never presented.
- RESET_PC=16'hFFFE, sequential fetch -> dec_pc FFFE, FFFF, 0000; dec_pc_inc FFFF, 0000, 0001.
- FETCH_HALT_DETECT_EN, IM[2]=F000 -> F000 presented, halted=1, im_rd_en stays 0; redirect to 0 resumes fetch, halted=0.
- rst asserted with queue full and redirect=1 same cycle -> dec_valid=0, fetch restarts at RESET_PC.
